// File: rtl/serial_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_addsub_pkg
// Brief   : Shared types and helpers for the bit-serial add/sub unit.
// Revision: 1.0 - initial release
// ============================================================================
package serial_addsub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed max (sign=0) or signed min (sign=1) for a width up to 64 bits.
    function automatic logic [63:0] sat_value(input logic sign, input int width);
        logic [63:0] msb;
        msb = 64'd1 << (width - 1);
        return sign ? msb : (msb - 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_addsub_if.sv
`default_nettype none
// ============================================================================
// Module  : serial_addsub_if
// Brief   : Start/done request and result bundle for serial_addsub.
// Revision: 1.0 - initial release
// ============================================================================
interface serial_addsub_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             se;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;

    modport master (
        output start, se, a, b,
        input  busy, done, s, c, v
    );

    modport slave (
        input  start, se, a, b,
        output busy, done, s, c, v
    );
endinterface
`default_nettype wire

// File: rtl/serial_fa_cell.sv
`default_nettype none
// ============================================================================
// Module  : serial_fa_cell
// Brief   : Single-bit full adder shared by every bit-step of serial_addsub.
// Revision: 1.0 - initial release
// ============================================================================
module serial_fa_cell (
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output logic      sum,
    output logic      cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module  : serial_addsub
// Brief   : Bit-serial two's-complement add/sub, LSB first over WIDTH clocks.
//           Define SERIAL_ADDSUB_SAT_EN to saturate s on signed overflow
//           (WIDTH <= 64 in that build).
// Revision: 1.0 - initial release
// ============================================================================
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    serial_addsub_if.slave  bus
);
    localparam int             c_cnt_w = $clog2(WIDTH);
    localparam [c_cnt_w-1:0]   c_last  = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-2:0]   r_res_sh;
    logic               r_cy;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_s;
    logic               r_c;
    logic               r_v;

    logic               w_sum;
    logic               w_cout;
    logic               w_v;
    logic [WIDTH-1:0]   w_shift;
    logic [WIDTH-1:0]   w_s_final;

    serial_fa_cell u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_cy),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // On the MSB step r_cy is the carry into the MSB, so overflow falls out directly.
    assign w_v     = r_cy ^ w_cout;
    assign w_shift = {w_sum, r_res_sh};

`ifdef SERIAL_ADDSUB_SAT_EN
    // On the MSB step r_a_sh[0] holds A's sign bit.
    assign w_s_final = w_v ? WIDTH'(sat_value(r_a_sh[0], WIDTH)) : w_shift;
`else
    assign w_s_final = w_shift;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_cy     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_s      <= '0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= bus.b ^ {WIDTH{bus.se}};
                        r_cy    <= bus.se;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_cy     <= w_cout;
                    r_res_sh <= w_shift[WIDTH-1:1];
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_s     <= w_s_final;
                        r_c     <= w_cout;
                        r_v     <= w_v;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.s    = r_s;
    assign bus.c    = r_c;
    assign bus.v    = r_v;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_addsub
// Brief   : Directed self-checking bench for serial_addsub at WIDTH=4.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_addsub;
    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;
    int   n_total = 0;
    int   n_bad   = 0;

    serial_addsub_if #(.WIDTH(WIDTH)) bus ();

    serial_addsub #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive a request so the next rising edge accepts it, then drop start.
    task automatic issue(input logic se_i, input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i);
        bus.start = 1'b1;
        bus.se    = se_i;
        bus.a     = a_i;
        bus.b     = b_i;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!bus.done && cyc < 20);
    endtask

    task automatic check_result(input string tag, input int cyc, input logic [WIDTH-1:0] es,
                                input logic ec, input logic ev);
        chk({tag, "_lat"}, cyc, 4);
        chk({tag, "_s"}, 32'(bus.s), 32'(es));
        chk({tag, "_c"}, 32'(bus.c), 32'(ec));
        chk({tag, "_v"}, 32'(bus.v), 32'(ev));
        chk({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    logic [WIDTH-1:0] exp_sat2;
    logic [WIDTH-1:0] exp_sat4;

    initial begin
        int cyc;
        int seen;
`ifdef SERIAL_ADDSUB_SAT_EN
        exp_sat2 = 4'b0111;
        exp_sat4 = 4'b0111;
`else
        exp_sat2 = 4'b1011;
        exp_sat4 = 4'b1111;
`endif
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.se    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #12;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_s", 32'(bus.s), 0);
        chk("rst_cv", 32'({bus.c, bus.v}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: -1 + -1
        issue(1'b0, 4'b1111, 4'b1111);
        chk("t1_busy_run", 32'(bus.busy), 1);
        wait_done(cyc);
        check_result("t1", cyc, 4'b1110, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("t1_done_pulse", 32'(bus.done), 0);

        // 2: 4 + 7 overflows
        issue(1'b0, 4'b0100, 4'b0111);
        wait_done(cyc);
        check_result("t2", cyc, exp_sat2, 1'b0, 1'b1);
        @(posedge clk); #1;

        // 3: subtract, then back-to-back subtract issued in the DONE cycle
        issue(1'b1, 4'b0000, 4'b1111);
        wait_done(cyc);
        check_result("t3a", cyc, 4'b0001, 1'b0, 1'b0);
        issue(1'b1, 4'b1101, 4'b1010);
        chk("t3b_busy", 32'(bus.busy), 1);
        chk("t3b_hold_s", 32'(bus.s), 32'(4'b0001));
        wait_done(cyc);
        check_result("t3b", cyc, 4'b0011, 1'b1, 1'b0);
        @(posedge clk); #1;

        // 4: 7 - (-8) overflows
        issue(1'b1, 4'b0111, 4'b1000);
        wait_done(cyc);
        check_result("t4", cyc, exp_sat4, 1'b0, 1'b1);
        @(posedge clk); #1;

        // 5: second start during RUN must be ignored
        issue(1'b0, 4'b0011, 4'b0010);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.se    = 1'b1;
        bus.a     = 4'b1111;
        bus.b     = 4'b0001;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("t5_no_early_done", 32'(bus.done), 0);
        wait_done(cyc);
        check_result("t5", cyc + 2, 4'b0101, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("t5_no_restart", 32'(bus.busy), 0);

        // 6: async reset mid-operation
        issue(1'b0, 4'b0001, 4'b0001);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(bus.busy), 0);
        chk("t6_rst_done", 32'(bus.done), 0);
        chk("t6_rst_s", 32'(bus.s), 0);
        chk("t6_rst_cv", 32'({bus.c, bus.v}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen++;
        end
        chk("t6_no_done", seen, 0);
        issue(1'b1, 4'b0101, 4'b0011);
        wait_done(cyc);
        check_result("t6", cyc, 4'b0010, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
